// File: rtl/bpu_param_btb_ras.sv
// ---------------------------------------------------------------------------
// bpu_param_btb_ras
//
// Fetch-stage branch predictor. It has three parts:
//   * a direct-mapped BTB. Each entry holds a valid bit, a tag, the branch
//     type, the taken target and a saturating direction counter.
//   * a speculative return-address stack (RAS). Every prediction carries a
//     {ptr,count} checkpoint, so a mispredicting branch can roll the stack
//     back to the state it had when that branch was predicted.
//   * a two-state redirect FSM (IDLE/CORRECTION). On a mispredict it raises
//     corr_valid for exactly one cycle.
//
// A lookup on f_pc in cycle N appears on the registered p_* outputs in
// cycle N+1. Verify results from execute train the BTB. When a verify result
// reports a mispredict, it also repairs the RAS and starts a redirect.
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   f_valid, f_pc   fetch request
//   p_*             registered prediction for the previous cycle's request
//   v_*             verify result from execute (p_cnt / p_ras_ckpt come back
//                   as v_cnt / v_ras_ckpt)
//   corr_valid,     one-cycle fetch redirect
//   corr_target
//   dbg_state,      observability taps for checkers: FSM state
//   dbg_ras_ptr,    (0 = IDLE, 1 = CORRECTION), RAS write pointer and
//   dbg_ras_count   RAS occupancy
//
// Handshake: there is no back-pressure. f_valid and v_valid are single-cycle
// qualifiers with no ready signal, so a request is consumed in every cycle
// where its valid is 1. p_valid and corr_valid are single-cycle strobes that
// the consumer must take in the cycle they are high.
// ---------------------------------------------------------------------------
module bpu_param_btb_ras #(
  parameter int PC_W      = 32,
  parameter int BTB_IDX_W = 10,
  parameter int CNT_W     = 2,
  parameter int RAS_DEPTH = 8,
  localparam int RAS_PW   = $clog2(RAS_DEPTH),
  localparam int CKPT_W   = RAS_PW + RAS_PW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_valid,
  input  logic [PC_W-1:0]   f_pc,
  output logic              p_valid,
  output logic              p_taken,
  output logic [PC_W-1:0]   p_target,
  output logic [1:0]        p_br_type,
  output logic [CNT_W-1:0]  p_cnt,
  output logic [CKPT_W-1:0] p_ras_ckpt,
  input  logic              v_valid,
  input  logic [PC_W-1:0]   v_pc,
  input  logic [1:0]        v_br_type,
  input  logic              v_taken,
  input  logic [PC_W-1:0]   v_target,
  input  logic [CNT_W-1:0]  v_cnt,
  input  logic              v_mispredict,
  input  logic [CKPT_W-1:0] v_ras_ckpt,
  output logic              corr_valid,
  output logic [PC_W-1:0]   corr_target,
  output logic              dbg_state,
  output logic [RAS_PW-1:0] dbg_ras_ptr,
  output logic [RAS_PW:0]   dbg_ras_count
);

  localparam int BTB_N = 1 << BTB_IDX_W;
  localparam int TAG_W = PC_W - BTB_IDX_W - 2;

  localparam logic [1:0] BR_NONE = 2'd0;
  localparam logic [1:0] BR_COND = 2'd1;
  localparam logic [1:0] BR_CALL = 2'd2;
  localparam logic [1:0] BR_RET  = 2'd3;

  localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_WEAK_T = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_WEAK_N = CNT_WEAK_T - CNT_ONE;
  localparam logic [RAS_PW-1:0] PTR_ONE    = RAS_PW'(1);
  localparam logic [RAS_PW:0]   RC_ONE     = (RAS_PW + 1)'(1);
  localparam logic [RAS_PW:0]   RAS_FULL   = (RAS_PW + 1)'(RAS_DEPTH);
  localparam logic [PC_W-1:0]   PC_STEP    = PC_W'(8);

  typedef enum logic {S_IDLE = 1'b0, S_CORR = 1'b1} state_t;

  // BTB storage. Only the valid bits need a reset.
  logic [BTB_N-1:0] btb_valid;
  logic [TAG_W-1:0] btb_tag  [BTB_N];
  logic [1:0]       btb_type [BTB_N];
  logic [PC_W-1:0]  btb_tgt  [BTB_N];
  logic [CNT_W-1:0] btb_cnt  [BTB_N];

  // RAS: ras_ptr points at the next free slot, so the top of stack is ptr-1.
  logic [PC_W-1:0]   ras_mem [RAS_DEPTH];
  logic [RAS_PW-1:0] ras_ptr;
  logic [RAS_PW:0]   ras_count;

  state_t state;

  // ---------------- lookup ----------------
  logic [BTB_IDX_W-1:0] f_idx;
  logic [TAG_W-1:0]     f_tag;
  logic [PC_W-1:0]      f_seq;
  logic                 rd_hit;
  logic [1:0]           rd_type;
  logic [PC_W-1:0]      ras_top;
  logic                 lk_taken;
  logic [PC_W-1:0]      lk_target;
  logic [1:0]           lk_type;
  logic [CNT_W-1:0]     lk_cnt;
  logic                 recover;
  logic                 p_fire;

  assign f_idx   = f_pc[BTB_IDX_W+1:2];
  assign f_tag   = f_pc[PC_W-1:BTB_IDX_W+2];
  assign f_seq   = f_pc + PC_STEP;
  assign rd_hit  = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
  assign rd_type = btb_type[f_idx];
  assign ras_top = ras_mem[ras_ptr - PTR_ONE];
  assign recover = v_valid && v_mispredict;
  // A prediction is only produced (and the RAS only moves speculatively)
  // when no redirect is pending or starting in this cycle.
  assign p_fire  = f_valid && (state == S_IDLE) && !recover;

  always_comb begin
    lk_taken  = 1'b0;
    lk_target = f_seq;
    lk_type   = BR_NONE;
    lk_cnt    = '0;
    if (rd_hit) begin
      lk_type = rd_type;
      lk_cnt  = btb_cnt[f_idx];
      case (rd_type)
        BR_COND: begin
          lk_taken = btb_cnt[f_idx][CNT_W-1];
          if (btb_cnt[f_idx][CNT_W-1]) lk_target = btb_tgt[f_idx];
        end
        BR_CALL: begin
          lk_taken  = 1'b1;
          lk_target = btb_tgt[f_idx];
        end
        BR_RET: begin
          if (ras_count != '0) begin
            lk_taken  = 1'b1;
            lk_target = ras_top;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- BTB training ----------------
  logic [BTB_IDX_W-1:0] v_idx;
  logic [TAG_W-1:0]     v_tag;
  logic                 v_tag_hit;
  logic                 btb_we;
  logic [CNT_W-1:0]     v_cnt_new;
  logic [PC_W-1:0]      v_seq;

  assign v_idx     = v_pc[BTB_IDX_W+1:2];
  assign v_tag     = v_pc[PC_W-1:BTB_IDX_W+2];
  assign v_seq     = v_pc + PC_STEP;
  assign v_tag_hit = btb_valid[v_idx] && (btb_tag[v_idx] == v_tag);
  assign btb_we    = v_valid && (v_br_type != BR_NONE);

  // The counter update starts from the counter the branch carried through
  // the pipe (v_cnt), not from the current table value. A fresh allocation
  // starts weakly in the observed direction.
  always_comb begin
    v_cnt_new = v_taken ? CNT_WEAK_T : CNT_WEAK_N;
    if (v_tag_hit) begin
      if (v_taken) v_cnt_new = (v_cnt == CNT_MAX) ? CNT_MAX : v_cnt + CNT_ONE;
      else         v_cnt_new = (v_cnt == '0)      ? '0      : v_cnt - CNT_ONE;
    end
  end

  // ---------------- RAS next state ----------------
  logic [RAS_PW-1:0] ck_ptr;
  logic [RAS_PW:0]   ck_count;
  logic [RAS_PW-1:0] ras_ptr_n;
  logic [RAS_PW:0]   ras_count_n;
  logic              ras_we;
  logic [RAS_PW-1:0] ras_waddr;
  logic [PC_W-1:0]   ras_wdata;

  assign ck_ptr   = v_ras_ckpt[CKPT_W-1 -: RAS_PW];
  assign ck_count = v_ras_ckpt[RAS_PW:0];

  // Recovery rewinds to the checkpoint and then replays the verified op.
  // Any speculative op in the same cycle came from the wrong path and is
  // dropped. Occupancy saturates at RAS_DEPTH, so an overflowing push
  // silently overwrites the oldest entry.
  always_comb begin
    ras_ptr_n   = ras_ptr;
    ras_count_n = ras_count;
    ras_we      = 1'b0;
    ras_waddr   = ras_ptr;
    ras_wdata   = f_seq;
    if (recover) begin
      ras_ptr_n   = ck_ptr;
      ras_count_n = ck_count;
      if (v_br_type == BR_CALL) begin
        ras_we      = 1'b1;
        ras_waddr   = ck_ptr;
        ras_wdata   = v_seq;
        ras_ptr_n   = ck_ptr + PTR_ONE;
        ras_count_n = (ck_count >= RAS_FULL) ? RAS_FULL : ck_count + RC_ONE;
      end else if (v_br_type == BR_RET && ck_count != '0) begin
        ras_ptr_n   = ck_ptr - PTR_ONE;
        ras_count_n = ck_count - RC_ONE;
      end
    end else if (p_fire && rd_hit) begin
      if (rd_type == BR_CALL) begin
        ras_we      = 1'b1;
        ras_ptr_n   = ras_ptr + PTR_ONE;
        ras_count_n = (ras_count >= RAS_FULL) ? RAS_FULL : ras_count + RC_ONE;
      end else if (rd_type == BR_RET && ras_count != '0) begin
        ras_ptr_n   = ras_ptr - PTR_ONE;
        ras_count_n = ras_count - RC_ONE;
      end
    end
  end

  // ---------------- state with reset ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      btb_valid   <= '0;
      ras_ptr     <= '0;
      ras_count   <= '0;
      state       <= S_IDLE;
      corr_valid  <= 1'b0;
      corr_target <= '0;
      p_valid     <= 1'b0;
      p_taken     <= 1'b0;
      p_target    <= '0;
      p_br_type   <= '0;
      p_cnt       <= '0;
      p_ras_ckpt  <= '0;
    end else begin
      if (btb_we) btb_valid[v_idx] <= 1'b1;
      ras_ptr   <= ras_ptr_n;
      ras_count <= ras_count_n;

      p_valid <= p_fire;
      if (f_valid) begin
        p_taken    <= lk_taken;
        p_target   <= lk_target;
        p_br_type  <= lk_type;
        p_cnt      <= lk_cnt;
        p_ras_ckpt <= {ras_ptr, ras_count};
      end

      // A mispredict that arrives during CORRECTION still trains the BTB and
      // repairs the RAS, but it does not start a second redirect.
      case (state)
        S_IDLE: begin
          if (recover) begin
            state       <= S_CORR;
            corr_valid  <= 1'b1;
            corr_target <= v_taken ? v_target : v_seq;
          end
        end
        S_CORR: begin
          state      <= S_IDLE;
          corr_valid <= 1'b0;
        end
        default: begin
          state      <= S_IDLE;
          corr_valid <= 1'b0;
        end
      endcase
    end
  end

  // ---------------- storage without reset ----------------
  always_ff @(posedge clk) begin
    if (!reset && btb_we) begin
      btb_tag[v_idx]  <= v_tag;
      btb_type[v_idx] <= v_br_type;
      btb_tgt[v_idx]  <= v_target;
      btb_cnt[v_idx]  <= v_cnt_new;
    end
    if (!reset && ras_we) ras_mem[ras_waddr] <= ras_wdata;
  end

  assign dbg_state     = state;
  assign dbg_ras_ptr   = ras_ptr;
  assign dbg_ras_count = ras_count;

endmodule

// File: tb/tb_bpu_param_btb_ras.sv
// ---------------------------------------------------------------------------
// tb_bpu_param_btb_ras
//
// Bench for bpu_param_btb_ras with its default parameters.
// A table of fetch/verify/reset vectors covers BTB training, counter
// saturation, tag misses, pc+8 wrap and RAS push/pop/overflow. Each fetch
// pushes its expected prediction onto exp_q, and the entry is popped and
// compared once the registered output appears. Hand-written sequences cover
// the redirect FSM and RAS checkpoint recovery.
// ---------------------------------------------------------------------------
module tb_bpu_param_btb_ras;

  localparam int PC_W   = 32;
  localparam int CNT_W  = 2;
  localparam int RAS_PW = 3;
  localparam int CKPT_W = 2 * RAS_PW + 1;
  localparam int EW     = 1 + CNT_W + 1 + 1 + PC_W + 2;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              reset;
  logic              f_valid;
  logic [PC_W-1:0]   f_pc;
  logic              p_valid;
  logic              p_taken;
  logic [PC_W-1:0]   p_target;
  logic [1:0]        p_br_type;
  logic [CNT_W-1:0]  p_cnt;
  logic [CKPT_W-1:0] p_ras_ckpt;
  logic              v_valid;
  logic [PC_W-1:0]   v_pc;
  logic [1:0]        v_br_type;
  logic              v_taken;
  logic [PC_W-1:0]   v_target;
  logic [CNT_W-1:0]  v_cnt;
  logic              v_mispredict;
  logic [CKPT_W-1:0] v_ras_ckpt;
  logic              corr_valid;
  logic [PC_W-1:0]   corr_target;
  logic              dbg_state;
  logic [RAS_PW-1:0] dbg_ras_ptr;
  logic [RAS_PW:0]   dbg_ras_count;

  always #5 clk = ~clk;

  bpu_param_btb_ras dut (
    .clk(clk), .reset(reset),
    .f_valid(f_valid), .f_pc(f_pc),
    .p_valid(p_valid), .p_taken(p_taken), .p_target(p_target),
    .p_br_type(p_br_type), .p_cnt(p_cnt), .p_ras_ckpt(p_ras_ckpt),
    .v_valid(v_valid), .v_pc(v_pc), .v_br_type(v_br_type), .v_taken(v_taken),
    .v_target(v_target), .v_cnt(v_cnt), .v_mispredict(v_mispredict),
    .v_ras_ckpt(v_ras_ckpt),
    .corr_valid(corr_valid), .corr_target(corr_target),
    .dbg_state(dbg_state), .dbg_ras_ptr(dbg_ras_ptr), .dbg_ras_count(dbg_ras_count)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected prediction layout: {chk_cnt, cnt, valid, taken, target, type}
  task automatic sb_compare(input string tag);
    logic [EW-1:0]    e;
    logic             e_chk_cnt;
    logic [CNT_W-1:0] e_cnt;
    logic             e_valid;
    logic             e_taken;
    logic [PC_W-1:0]  e_target;
    logic [1:0]       e_type;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard empty got 0 expected 1 entry", tag);
    end else begin
      e = exp_q.pop_front();
      {e_chk_cnt, e_cnt, e_valid, e_taken, e_target, e_type} = e;
      check({tag, ".p_valid"},   64'(p_valid),   64'(e_valid));
      check({tag, ".p_taken"},   64'(p_taken),   64'(e_taken));
      check({tag, ".p_target"},  64'(p_target),  64'(e_target));
      check({tag, ".p_br_type"}, 64'(p_br_type), 64'(e_type));
      if (e_chk_cnt) check({tag, ".p_cnt"}, 64'(p_cnt), 64'(e_cnt));
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit               rst;
    bit               fetch;
    bit               verify;
    logic [PC_W-1:0]  pc;
    logic [1:0]       typ;
    bit               taken;
    logic [PC_W-1:0]  tgt;
    logic [CNT_W-1:0] vcnt;
    bit               e_taken;
    logic [PC_W-1:0]  e_target;
    logic [1:0]       e_type;
    bit               chk_cnt;
    logic [CNT_W-1:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit rst, input bit fe, input bit ve,
                              input logic [PC_W-1:0] pc, input logic [1:0] typ,
                              input bit taken, input logic [PC_W-1:0] tgt,
                              input logic [CNT_W-1:0] vcnt, input bit e_taken,
                              input logic [PC_W-1:0] e_target, input logic [1:0] e_type,
                              input bit chk_cnt, input logic [CNT_W-1:0] e_cnt);
    vec_t v;
    v.rst = rst; v.fetch = fe; v.verify = ve; v.pc = pc; v.typ = typ;
    v.taken = taken; v.tgt = tgt; v.vcnt = vcnt; v.e_taken = e_taken;
    v.e_target = e_target; v.e_type = e_type; v.chk_cnt = chk_cnt; v.e_cnt = e_cnt;
    tbl.push_back(v);
  endfunction

  function automatic void add_r();
    add(1, 0, 0, '0, 2'd0, 0, '0, '0, 0, '0, 2'd0, 0, '0);
  endfunction

  function automatic void add_v(input logic [PC_W-1:0] pc, input logic [1:0] typ,
                                input bit taken, input logic [PC_W-1:0] tgt,
                                input logic [CNT_W-1:0] vcnt);
    add(0, 0, 1, pc, typ, taken, tgt, vcnt, 0, '0, 2'd0, 0, '0);
  endfunction

  function automatic void add_f(input logic [PC_W-1:0] pc, input bit e_taken,
                                input logic [PC_W-1:0] e_target, input logic [1:0] e_type,
                                input bit chk_cnt, input logic [CNT_W-1:0] e_cnt);
    add(0, 1, 0, pc, 2'd0, 0, '0, '0, e_taken, e_target, e_type, chk_cnt, e_cnt);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    reset = 1'b0; f_valid = 1'b0; f_pc = '0;
    v_valid = 1'b0; v_pc = '0; v_br_type = 2'd0; v_taken = 1'b0;
    v_target = '0; v_cnt = '0; v_mispredict = 1'b0; v_ras_ckpt = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".reset_p"}, 64'({p_valid, p_taken, p_target, p_br_type, p_cnt, p_ras_ckpt}), 64'd0);
    check({tag, ".reset_corr"}, 64'({corr_valid, corr_target}), 64'd0);
    check({tag, ".reset_state"}, 64'({dbg_state, dbg_ras_ptr, dbg_ras_count}), 64'd0);
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // ---------------- test body ----------------
  initial begin
    drive_idle();
    reset = 1'b1;

    // Test 1: reset state and a plain miss
    add_r(); add_r();
    add_f(32'h0040_0000, 0, 32'h0040_0008, 2'd0, 0, '0);

    // Test 2: conditional branch training and counter clamps
    add_v(32'h1000, 2'd1, 1, 32'h2000, 2'd0);              // miss -> allocate weak taken (2)
    add_f(32'h1000, 1, 32'h2000, 2'd1, 1, 2'd2);
    add_v(32'h1000, 2'd1, 0, 32'h2000, 2'd2);              // 2 -> 1
    add_v(32'h1000, 2'd1, 0, 32'h2000, 2'd1);              // 1 -> 0
    add_f(32'h1000, 0, 32'h1008, 2'd1, 1, 2'd0);
    add_v(32'h1000, 2'd1, 1, 32'h2000, 2'd3);              // saturate at 3
    add_f(32'h1000, 1, 32'h2000, 2'd1, 1, 2'd3);
    add_v(32'h1000, 2'd1, 0, 32'h2000, 2'd0);              // clamp at 0
    add_f(32'h1000, 0, 32'h1008, 2'd1, 1, 2'd0);
    // Same-cycle write and read: the lookup sees the old counter (0)
    add(0, 1, 1, 32'h1000, 2'd1, 1, 32'h2000, 2'd0, 0, 32'h1008, 2'd1, 1, 2'd0);
    add_f(32'h1000, 0, 32'h1008, 2'd1, 1, 2'd1);
    add_v(32'h1000, 2'd0, 1, 32'h7770, 2'd3);              // type 0: no write
    add_f(32'h1000, 0, 32'h1008, 2'd1, 1, 2'd1);
    add_f(32'h5000, 0, 32'h5008, 2'd0, 0, '0);             // same index, other tag
    add_v(32'h5000, 2'd1, 0, 32'h6000, 2'd3);              // allocate weak not-taken (1)
    add_f(32'h5000, 0, 32'h5008, 2'd1, 1, 2'd1);
    add_f(32'h1000, 0, 32'h1008, 2'd0, 0, '0);             // evicted
    add_f(32'hFFFF_FFFC, 0, 32'h0000_0004, 2'd0, 0, '0);   // pc+8 wraps

    // Test 3: calls, returns and an empty RAS
    add_r();
    add_v(32'h100, 2'd2, 1, 32'hA000, 2'd0);
    add_v(32'h200, 2'd2, 1, 32'hB000, 2'd0);
    add_v(32'h300, 2'd3, 1, 32'hC000, 2'd0);
    add_f(32'h100, 1, 32'hA000, 2'd2, 0, '0);
    add_f(32'h200, 1, 32'hB000, 2'd2, 0, '0);
    add_f(32'h300, 1, 32'h208,  2'd3, 0, '0);
    add_f(32'h300, 1, 32'h108,  2'd3, 0, '0);
    add_f(32'h300, 0, 32'h308,  2'd3, 0, '0);

    // Test 4: RAS overflow. Nine calls, then nine returns.
    add_r();
    for (int i = 0; i < 9; i++) add_v(32'h4100 + 32'(i * 16), 2'd2, 1, 32'h8000 + 32'(i * 16), 2'd0);
    add_v(32'h3800, 2'd3, 1, 32'hC000, 2'd0);
    for (int i = 0; i < 9; i++) add_f(32'h4100 + 32'(i * 16), 1, 32'h8000 + 32'(i * 16), 2'd2, 0, '0);
    for (int k = 0; k < 8; k++) add_f(32'h3800, 1, 32'h4108 + 32'((8 - k) * 16), 2'd3, 0, '0);
    add_f(32'h3800, 0, 32'h3808, 2'd3, 0, '0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive_idle();
      reset     = tbl[i].rst;
      f_valid   = tbl[i].fetch;
      f_pc      = tbl[i].pc;
      v_valid   = tbl[i].verify;
      v_pc      = tbl[i].pc;
      v_br_type = tbl[i].typ;
      v_taken   = tbl[i].taken;
      v_target  = tbl[i].tgt;
      v_cnt     = tbl[i].vcnt;
      if (tbl[i].fetch)
        exp_q.push_back({tbl[i].chk_cnt, tbl[i].e_cnt, 1'b1, tbl[i].e_taken,
                         tbl[i].e_target, tbl[i].e_type});
      tick();
      if (tbl[i].rst) check_reset_state($sformatf("vec%0d", i));
      if (tbl[i].fetch) sb_compare($sformatf("vec%0d", i));
    end
    drive_idle();
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    // Test 5: a mispredict concurrent with a fetch; a second mispredict during CORRECTION
    do_reset();
    f_valid = 1'b1; f_pc = 32'h600;
    v_valid = 1'b1; v_mispredict = 1'b1; v_pc = 32'h500; v_br_type = 2'd1;
    v_taken = 1'b1; v_target = 32'h900;
    tick();
    check("t5.p_valid_blocked", 64'(p_valid), 64'd0);
    check("t5.corr_valid",      64'(corr_valid), 64'd1);
    check("t5.corr_target",     64'(corr_target), 64'h900);
    check("t5.state_corr",      64'(dbg_state), 64'd1);
    f_valid = 1'b1; f_pc = 32'h600;
    v_valid = 1'b1; v_mispredict = 1'b1; v_pc = 32'h700; v_br_type = 2'd1;
    v_taken = 1'b1; v_target = 32'hA00;
    tick();
    check("t5.p_valid_in_corr", 64'(p_valid), 64'd0);
    check("t5.corr_one_cycle",  64'(corr_valid), 64'd0);
    check("t5.state_idle",      64'(dbg_state), 64'd0);
    drive_idle();
    f_valid = 1'b1; f_pc = 32'h500;
    tick();
    check("t5.fetch500", 64'({p_valid, p_taken, p_target}), 64'({1'b1, 1'b1, 32'h900}));
    f_pc = 32'h700;
    tick();
    check("t5.fetch700", 64'({p_valid, p_taken, p_target}), 64'({1'b1, 1'b1, 32'hA00}));

    // Test 6: checkpoint recovery, then reset in the middle of CORRECTION
    do_reset();
    v_valid = 1'b1; v_pc = 32'h100; v_br_type = 2'd2; v_taken = 1'b1; v_target = 32'hA000;
    tick();
    drive_idle();
    for (int k = 0; k < 5; k++) begin
      f_valid = 1'b1; f_pc = 32'h100;
      tick();
      check($sformatf("t6.call%0d_ckpt", k), 64'(p_ras_ckpt), 64'({3'(k), 4'(k)}));
      check($sformatf("t6.call%0d_tgt", k), 64'({p_valid, p_taken, p_target}), 64'({1'b1, 1'b1, 32'hA000}));
    end
    drive_idle();
    check("t6.ras_after_calls", 64'({dbg_ras_ptr, dbg_ras_count}), 64'({3'd5, 4'd5}));
    v_valid = 1'b1; v_mispredict = 1'b1; v_pc = 32'h300; v_br_type = 2'd3;
    v_taken = 1'b1; v_target = 32'h104; v_ras_ckpt = {3'd3, 4'd3};
    tick();
    check("t6.ras_recovered", 64'({dbg_ras_ptr, dbg_ras_count}), 64'({3'd2, 4'd2}));
    check("t6.corr", 64'({corr_valid, corr_target}), 64'({1'b1, 32'h104}));
    reset = 1'b1;
    tick();
    check("t6.reset_corr_valid", 64'(corr_valid), 64'd0);
    check("t6.reset_state", 64'({dbg_state, dbg_ras_ptr, dbg_ras_count}), 64'd0);
    drive_idle();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
